adc_sample_fifo: RTL and testbench
==================================

Name: adc_sample_fifo

Overview:
- Consumer stage directly downstream of the serial ADC receiver in the equalizer datapath.
- Captures each 12-bit offset-binary sample presented with the receiver's one-cycle done tick.
- Converts each sample to left-justified two's complement and buffers it in a small FIFO.
- Delivers samples to the filter stage over a valid/ready handshake, flagging lost samples.

Parameters:
- DATA_W, 12: width of the incoming ADC sample.
- OUT_W, 16: width of the signed output word; must satisfy OUT_W >= DATA_W.
- DEPTH, 8: FIFO entries; must be a power of two, >= 2.
- ADDR_W, 3: log2(DEPTH).

Ports:
- sclk  input  1: system clock. All logic is rising-edge.
- rst  input  1: asynchronous, active-high reset.
- rx_done_tick  input  1: one-cycle strobe; din is valid in this cycle.
- din  input  DATA_W: offset-binary ADC sample (0x800 = mid-scale).
- flush  input  1: synchronous clear of FIFO contents and the overflow flag.
- m_ready  input  1: downstream accepts the head word this cycle.
- m_valid  output  1: FIFO non-empty; m_data is valid.
- m_data  output  OUT_W: converted head sample.
- level  output  ADDR_W+1: current occupancy, 0..DEPTH.
- overflow  output  1: sticky; set when a sample was dropped.

Behaviour:
- Reset (asynchronous, rst=1):
  - Read/write pointers and level go to 0.
  - m_valid=0, overflow=0, m_data=0.
  - Memory contents are don't-care.
  - Reset asserted mid-operation discards all stored samples immediately, with no wait for a clock edge.
- Conversion (combinational, applied at write):
  - stored = {~din[DATA_W-1], din[DATA_W-2:0], (OUT_W-DATA_W) zero bits}.
  - Examples: 0x800->0x0000, 0xFFF->0x7FF0, 0x000->0x8000, 0x001->0x8010.
- Push condition: push = rx_done_tick & ~flush & (level<DEPTH | pop).
- Pop condition: pop = m_valid & m_ready & ~flush.
- Output timing:
  - m_data = mem[rd_ptr], driven combinationally from storage (first-word-fall-through).
  - m_valid = (level != 0).
  - When m_valid=0, m_data is held at the last value (0 after reset).
- Latency: a tick at rising edge N into an empty FIFO gives m_valid=1 and the converted word on m_data after edge N. There is no same-cycle bypass.
- Pointers: wr_ptr and rd_ptr each increment modulo DEPTH on push and pop respectively, wrapping naturally at ADDR_W bits.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Boundary cases:
  - Full (level=DEPTH), tick, no pop: sample is dropped, overflow<=1, contents unchanged.
  - Full, tick, pop in the same cycle: both occur; level stays at DEPTH; no overflow.
  - Empty, m_ready=1, no valid: no pop; pointers unchanged.
  - Empty and tick in the same cycle: push only.
- Flush: on the next edge, pointers=0, level=0, overflow=0, m_valid=0.
  - Flush has priority over a simultaneous tick (that sample is discarded, overflow not set) and over a simultaneous pop.
- Overflow stays at 1 until rst or flush, regardless of later pops.
- m_data must remain stable while m_valid=1 and m_ready=0, even if pushes occur.
- Handshake: downstream may hold m_ready high continuously. The sustained rate is 1 word/cycle, well above the ADC frame rate (one tick per 16+ sclk).

Test Plan:
- Reset, then a single tick with din=0x800 -> after one edge m_valid=1, m_data=0x0000, level=1. Assert m_ready one cycle -> m_valid=0, level=0.
- Ticks with 0xFFF, 0x000, 0x001, 0xABC while m_ready=0 -> level=4. Then drain with m_ready=1 -> m_data sequence 0x7FF0, 0x8000, 0x8010, 0x2BC0, one per cycle; m_valid falls after the 4th.
- Wrap-around: 20 push/pop pairs with din=j (j=0..19), interleaved with m_ready toggling -> output order exactly j, each converted; level never exceeds 3; overflow stays 0.
- Overflow: fill 8 entries with m_ready=0, send 9th tick din=0x123 -> level=8, overflow=1. Drain -> 8 original samples only, 0x123 absent; overflow still 1.
- Full with simultaneous tick and pop: at level=8, tick din=0x7FF with m_ready=1 -> level stays 8, overflow=0, 0x7FF (as 0xFFF0) emerges last.
- Flush and tick in the same cycle at level=5 with overflow=1 -> next cycle level=0, m_valid=0, overflow=0. Assert rst asynchronously mid-drain -> m_valid falls before the next sclk edge.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: converts offset-binary ADC samples to left-justified two's complement
// and buffers them in a first-word-fall-through FIFO with a sticky overflow flag.
module adc_sample_fifo #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              rx_done_tick,
    input  logic [DATA_W-1:0] din,
    input  logic              flush,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [OUT_W-1:0]  m_data,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    logic [OUT_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [OUT_W-1:0]  conv, last_q;
    logic              push, pop;
    assign conv    = OUT_W'({~din[DATA_W-1], din[DATA_W-2:0]}) << (OUT_W - DATA_W);
    assign m_valid = level != '0;
    assign pop     = m_valid & m_ready & ~flush;
    assign push    = rx_done_tick & ~flush & (level != FULL | pop);
    // last_q keeps the most recently delivered word visible once the FIFO runs empty
    assign m_data  = m_valid ? mem[rd_ptr] : last_q;
    always_ff @(posedge sclk or posedge rst)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            last_q   <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                last_q <= mem[rd_ptr];
            end
            level <= (push & ~pop) ? level + (ADDR_W+1)'(1) :
                     (pop & ~push) ? level - (ADDR_W+1)'(1) : level;
            if (rx_done_tick & ~push) overflow <= 1'b1;
        end
    always_ff @(posedge sclk)
        if (push) mem[wr_ptr] <= conv;
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: randomized and directed checks of adc_sample_fifo against a queue-based model.
module tb_adc_sample_fifo;
    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_done_tick = 1'b0;
    logic [11:0] din = '0;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [15:0] m_data;
    logic [3:0]  level;
    logic        overflow;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] q[$];
    logic        ovf_m = 1'b0;
    logic [15:0] last_m = '0;

    adc_sample_fifo dut (
        .sclk(sclk), .rst(rst), .rx_done_tick(rx_done_tick), .din(din), .flush(flush),
        .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .level(level), .overflow(overflow)
    );

    always #5 sclk = ~sclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] cv(input logic [11:0] d);
        return 16'((int'(d) - 2048) * 16);
    endfunction

    function automatic logic [15:0] exp_data();
        return q.size() > 0 ? q[0] : last_m;
    endfunction

    task automatic model_reset();
        q.delete();
        ovf_m  = 1'b0;
        last_m = '0;
    endtask

    task automatic drive(input logic tk, input logic [11:0] d, input logic rdy, input logic fl);
        bit p, u;
        rx_done_tick = tk;
        din          = d;
        m_ready      = rdy;
        flush        = fl;
        p = q.size() > 0 && rdy && !fl;
        u = tk && !fl && (q.size() < 8 || p);
        if (fl) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            if (p) begin
                last_m = q[0];
                void'(q.pop_front());
            end
            if (tk && !u) ovf_m = 1'b1;
            if (u) q.push_back(cv(d));
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_tests++;
        if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_tests++;
        if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", m_data); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b1, 12'h800, 1'b0, 1'b0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 16'h0000 || level !== 4'd1) begin
            n_fail++;
            $display("FAIL single_push: got v=%b d=%h l=%0d want v=1 d=0000 l=1", m_valid, m_data, level);
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        n_tests++;
        if (m_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL single_pop: got v=%b l=%0d want v=0 l=0", m_valid, level);
        end
    endtask

    task automatic test_conversion();
        logic [11:0] ins [4] = '{12'hFFF, 12'h000, 12'h001, 12'hABC};
        logic [15:0] outs[4] = '{16'h7FF0, 16'h8000, 16'h8010, 16'h2BC0};
        for (int i = 0; i < 4; i++) drive(1'b1, ins[i], 1'b0, 1'b0);
        n_tests++;
        if (level !== 4'd4) begin n_fail++; $display("FAIL conv_level: got %0d want 4", level); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== outs[i]) begin
                n_fail++;
                $display("FAIL conv_data[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, outs[i]);
            end
            drive(1'b0, 12'h000, 1'b1, 1'b0);
        end
        n_tests++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL conv_empty: got v=%b want 0", m_valid); end
    endtask

    task automatic test_wrap();
        logic [15:0] seen[$];
        for (int j = 0; j < 20; j++) begin
            if (m_valid && m_ready) seen.push_back(m_data);
            drive(1'b1, 12'(j), 1'($urandom_range(0, 1)), 1'b0);
            n_tests++;
            if (level > 4'd3 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_bound: got l=%0d ovf=%b want l<=3 ovf=0", level, overflow);
            end
            if (m_valid) seen.push_back(m_data);
            drive(1'b0, 12'h000, 1'b1, 1'b0);
        end
        n_tests++;
        if (seen.size() != 20) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d words want 20", seen.size());
        end
        for (int j = 0; j < 20 && j < seen.size(); j++) begin
            n_tests++;
            if (seen[j] !== cv(12'(j))) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: got %h want %h", j, seen[j], cv(12'(j)));
            end
        end
    endtask

    task automatic test_overflow();
        logic [11:0] s[8];
        for (int i = 0; i < 8; i++) begin
            s[i] = 12'($urandom);
            drive(1'b1, s[i], 1'b0, 1'b0);
        end
        drive(1'b1, 12'h123, 1'b0, 1'b0);
        n_tests++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got l=%0d ovf=%b want l=8 ovf=1", level, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== cv(s[i])) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, cv(s[i]));
            end
            drive(1'b0, 12'h000, 1'b1, 1'b0);
        end
        n_tests++;
        if (m_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got v=%b ovf=%b want v=0 ovf=1", m_valid, overflow);
        end
    endtask

    task automatic test_full_pop();
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 12'($urandom), 1'b0, 1'b0);
        drive(1'b1, 12'h7FF, 1'b1, 1'b0);
        n_tests++;
        if (level !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_state: got l=%0d ovf=%b want l=8 ovf=0", level, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== exp_data()) begin
                n_fail++;
                $display("FAIL fullpop_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp_data());
            end
            if (i == 7) begin
                n_tests++;
                if (m_data !== 16'hFFF0) begin
                    n_fail++;
                    $display("FAIL fullpop_last: got %h want fff0", m_data);
                end
            end
            drive(1'b0, 12'h000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush_and_reset();
        time t0;
        for (int i = 0; i < 9; i++) drive(1'b1, 12'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 12'h000, 1'b1, 1'b0);
        n_tests++;
        if (level !== 4'd5 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got l=%0d ovf=%b want l=5 ovf=1", level, overflow);
        end
        drive(1'b1, 12'h456, 1'b1, 1'b1);
        n_tests++;
        if (level !== 4'd0 || m_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got l=%0d v=%b ovf=%b want l=0 v=0 ovf=0", level, m_valid, overflow);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 12'($urandom), 1'b0, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        rx_done_tick = 1'b0;
        flush        = 1'b0;
        t0 = $time;
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || level !== 4'd0 || m_data !== 16'h0000 || ($time - t0) >= 9) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b l=%0d d=%h want v=0 l=0 d=0000", m_valid, level, m_data);
        end
        model_reset();
        #2 rst = 1'b0;
        m_ready = 1'b0;
        @(posedge sclk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 2) == 0), 12'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 49) == 0));
            n_tests++;
            if (m_valid !== (q.size() > 0) || m_data !== exp_data() ||
                level !== 4'(q.size()) || overflow !== ovf_m) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b d=%h l=%0d ovf=%b want v=%b d=%h l=%0d ovf=%b",
                         c, m_valid, m_data, level, overflow, q.size() > 0, exp_data(), q.size(), ovf_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conversion();
        test_wrap();
        test_overflow();
        test_full_pop();
        test_flush_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
